// File: rtl/regs_cmd_arbiter_pkg.sv
// Shared definitions for the register command-bus arbiter: bus command
// encoding and the transaction FSM states.
package regs_cmd_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Only RD and WR produce a bus cycle; IDLE and 2'b11 are answered with an error.
  function automatic logic cmd_is_legal(input logic [1:0] c);
    return (c == CMD_RD) || (c == CMD_WR);
  endfunction

endpackage

// File: rtl/regs_cmd_arbiter_if.sv
// Requester-side and register-bus-side bundles of the command arbiter.
// Requesters are masters of the request bundle; the arbiter masters the bus.
interface regs_cmd_req_if #(
  parameter int addr_width = 8,
  parameter int data_width = 32,
  parameter int nreq       = 2
);
  logic [nreq-1:0]            req_valid;
  logic [nreq-1:0]            req_ready;
  logic [2*nreq-1:0]          req_cmd;
  logic [addr_width*nreq-1:0] req_addr;
  logic [data_width*nreq-1:0] req_wdata;
  logic [nreq-1:0]            rsp_valid;
  logic                       rsp_err;
  logic [data_width-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface regs_cmd_bus_if #(
  parameter int addr_width = 8,
  parameter int data_width = 32
);
  logic [1:0]            cmd;
  logic [addr_width-1:0] cmd_addr;
  logic [data_width-1:0] cmd_data_w;
  logic [data_width-1:0] cmd_data_r;

  modport master (
    output cmd, cmd_addr, cmd_data_w,
    input  cmd_data_r
  );

  modport slave (
    input  cmd, cmd_addr, cmd_data_w,
    output cmd_data_r
  );
endinterface

// File: rtl/regs_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin grant: the search starts one past i_ptr and
// wraps modulo nreq; the first pending request found wins.
module rr_arbiter #(
  parameter int nreq  = 2,
  parameter int ptr_w = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic [nreq-1:0]  i_req,
  input  logic [ptr_w-1:0] i_ptr,
  output logic [nreq-1:0]  o_grant
);

  logic [ptr_w-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= nreq; k++) begin
      w_idx = ptr_w'((int'(i_ptr) + k) % nreq);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_cmd_arbiter.sv
// Shares the register-block command bus between nreq requesters: round-robin
// accept, one bus command per accepted request, one-cycle response pulse.
module regs_cmd_arbiter
  import regs_cmd_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 32,
  parameter int nreq       = 2
) (
  input  logic           clk,
  input  logic           rst,
  regs_cmd_req_if.slave  req_if,
  regs_cmd_bus_if.master bus_if
);

  localparam int ptr_w = (nreq > 1) ? $clog2(nreq) : 1;

  state_t                r_state, w_state_next;
  logic [ptr_w-1:0]      r_last_g, w_last_g_next;
  logic [nreq-1:0]       r_gnt, w_gnt_next;
  logic [1:0]            r_lat_cmd, w_lat_cmd_next;
  logic [1:0]            r_cmd, w_cmd_next;
  logic [addr_width-1:0] r_cmd_addr, w_cmd_addr_next;
  logic [data_width-1:0] r_cmd_data_w, w_cmd_data_w_next;
  logic [nreq-1:0]       r_rsp_valid, w_rsp_valid_next;
  logic                  r_rsp_err, w_rsp_err_next;
  logic [data_width-1:0] r_rsp_rdata, w_rsp_rdata_next;

  logic [nreq-1:0]       w_grant;
  logic [nreq-1:0]       w_req_ready;
  logic [ptr_w-1:0]      w_sel_idx;
  logic [1:0]            w_sel_cmd;
  logic [addr_width-1:0] w_sel_addr;
  logic [data_width-1:0] w_sel_wdata;

  logic [1:0]            w_req_cmd   [nreq];
  logic [addr_width-1:0] w_req_addr  [nreq];
  logic [data_width-1:0] w_req_wdata [nreq];

  generate
    for (genvar gi = 0; gi < nreq; gi++) begin : g_unpack
      assign w_req_cmd[gi]   = req_if.req_cmd[2*gi +: 2];
      assign w_req_addr[gi]  = req_if.req_addr[addr_width*gi +: addr_width];
      assign w_req_wdata[gi] = req_if.req_wdata[data_width*gi +: data_width];
    end
  endgenerate

  rr_arbiter #(
    .nreq  (nreq),
    .ptr_w (ptr_w)
  ) u_rr (
    .i_req   (req_if.req_valid),
    .i_ptr   (r_last_g),
    .o_grant (w_grant)
  );

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < nreq; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = ptr_w'(i);
      end
    end
  end

  assign w_sel_cmd   = w_req_cmd[w_sel_idx];
  assign w_sel_addr  = w_req_addr[w_sel_idx];
  assign w_sel_wdata = w_req_wdata[w_sel_idx];

  // Output registers are loaded on the transition into the state that shows them.
  always_comb begin
    w_state_next      = r_state;
    w_last_g_next     = r_last_g;
    w_gnt_next        = r_gnt;
    w_lat_cmd_next    = r_lat_cmd;
    w_cmd_next        = CMD_IDLE;
    w_cmd_addr_next   = r_cmd_addr;
    w_cmd_data_w_next = r_cmd_data_w;
    w_rsp_valid_next  = '0;
    w_rsp_err_next    = 1'b0;
    w_rsp_rdata_next  = '0;
    w_req_ready       = '0;
    case (r_state)
      ST_IDLE: begin
        if (|req_if.req_valid) begin
          w_req_ready    = w_grant;
          w_last_g_next  = w_sel_idx;
          w_gnt_next     = w_grant;
          w_lat_cmd_next = w_sel_cmd;
          if (cmd_is_legal(w_sel_cmd)) begin
            w_state_next      = ST_ISSUE;
            w_cmd_next        = w_sel_cmd;
            w_cmd_addr_next   = w_sel_addr;
            w_cmd_data_w_next = w_sel_wdata;
          end else begin
            w_state_next     = ST_RESP;
            w_rsp_valid_next = w_grant;
            w_rsp_err_next   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (r_lat_cmd == CMD_WR) begin
          w_state_next     = ST_RESP;
          w_rsp_valid_next = r_gnt;
        end else begin
          w_state_next = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        w_state_next     = ST_RESP;
        w_rsp_valid_next = r_gnt;
        w_rsp_rdata_next = bus_if.cmd_data_r;
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_g     <= ptr_w'(nreq - 1);
      r_gnt        <= '0;
      r_lat_cmd    <= CMD_IDLE;
      r_cmd        <= CMD_IDLE;
      r_cmd_addr   <= '0;
      r_cmd_data_w <= '0;
      r_rsp_valid  <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_g     <= w_last_g_next;
      r_gnt        <= w_gnt_next;
      r_lat_cmd    <= w_lat_cmd_next;
      r_cmd        <= w_cmd_next;
      r_cmd_addr   <= w_cmd_addr_next;
      r_cmd_data_w <= w_cmd_data_w_next;
      r_rsp_valid  <= w_rsp_valid_next;
      r_rsp_err    <= w_rsp_err_next;
      r_rsp_rdata  <= w_rsp_rdata_next;
    end
  end

  assign req_if.req_ready  = w_req_ready;
  assign req_if.rsp_valid  = r_rsp_valid;
  assign req_if.rsp_err    = r_rsp_err;
  assign req_if.rsp_rdata  = r_rsp_rdata;
  assign bus_if.cmd        = r_cmd;
  assign bus_if.cmd_addr   = r_cmd_addr;
  assign bus_if.cmd_data_w = r_cmd_data_w;

endmodule

// File: tb/tb_regs_cmd_arbiter.sv
// Directed bench for regs_cmd_arbiter: transaction-timing model checked every
// cycle, plus literal checks of grant order, latencies and returned data.
module tb_regs_cmd_arbiter;
  import regs_cmd_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 2;

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regs_cmd_req_if #(.addr_width(AW), .data_width(DW), .nreq(NR)) req_if ();
  regs_cmd_bus_if #(.addr_width(AW), .data_width(DW)) bus_if ();

  regs_cmd_arbiter #(.addr_width(AW), .data_width(DW), .nreq(NR)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_if (req_if),
    .bus_if (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  item_t q0[$];
  item_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int g, input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    item_t it;
    it.cmd = c; it.addr = a; it.data = d;
    if (g == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic drive(input int g, input item_t it);
    req_if.req_cmd[2*g +: 2]     = it.cmd;
    req_if.req_addr[AW*g +: AW]  = it.addr;
    req_if.req_wdata[DW*g +: DW] = it.data;
    req_if.req_valid[g]          = 1'b1;
    $display("cycle %0d: req%0d presents cmd=%0d addr=%02h data=%08h", cyc, g, it.cmd, it.addr, it.data);
  endtask

  // Requester driver: drop a request once accepted, present the next queued one.
  logic [NR-1:0] acc_n = '0;
  always @(negedge clk) acc_n = req_if.req_valid & req_if.req_ready;

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < NR; g++) begin
      if (acc_n[g]) req_if.req_valid[g] = 1'b0;
      if (!req_if.req_valid[g] && !rst) begin
        if (g == 0 && q0.size() > 0) drive(0, q0.pop_front());
        else if (g == 1 && q1.size() > 0) drive(1, q1.pop_front());
      end
    end
  end

  // Register-block responder: returns its memory contents the cycle after a RD.
  logic [DW-1:0] bus_mem [256];
  logic          rd_seen = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  always @(negedge clk) begin
    rd_seen = (bus_if.cmd === CMD_RD);
    rd_addr = bus_if.cmd_addr;
    if (bus_if.cmd === CMD_WR) bus_mem[bus_if.cmd_addr] = bus_if.cmd_data_w;
  end
  always @(posedge clk) begin
    #1;
    bus_if.cmd_data_r = rd_seen ? bus_mem[rd_addr] : (32'hBAD0_0000 | 32'(cyc));
  end

  // Transaction model: each accept schedules its bus cycle, response and next free cycle.
  logic [DW-1:0] m_mem [256];
  int            m_free_at = 1 << 30;
  int            m_last_g  = NR - 1;
  int            m_bus_cyc = -1;
  int            m_rsp_cyc = -1;
  int            m_rsp_g   = 0;
  logic [1:0]    m_bus_cmd = '0;
  logic [AW-1:0] m_bus_addr = '0, m_hold_addr = '0;
  logic [DW-1:0] m_bus_data = '0, m_hold_data = '0, m_rsp_rdata = '0;
  logic          m_rsp_err = 1'b0;
  bit            m_live = 1'b0, m_after_rst = 1'b0;

  int            acc_cyc_log[$], acc_g_log[$], rsp_cyc_log[$], rsp_g_log[$], bus_cyc_log[$];
  logic          rsp_err_log[$];
  logic [DW-1:0] rsp_data_log[$];
  logic [AW-1:0] bus_addr_log[$];
  logic [DW-1:0] bus_data_log[$];

  always @(negedge clk) begin : model_cmp
    logic [NR-1:0] e_ready, e_rsp;
    logic [1:0]    e_cmd, a_cmd;
    logic [AW-1:0] e_addr, a_addr;
    logic [DW-1:0] e_data, e_rdata, a_data;
    logic          e_err;
    int            g;

    e_ready = '0;
    if (cyc >= m_free_at) begin
      for (int k = 1; k <= NR; k++) begin
        g = (m_last_g + k) % NR;
        if (e_ready == '0 && req_if.req_valid[g]) e_ready[g] = 1'b1;
      end
    end
    e_cmd   = (cyc == m_bus_cyc) ? m_bus_cmd  : CMD_IDLE;
    e_addr  = (cyc == m_bus_cyc) ? m_bus_addr : m_hold_addr;
    e_data  = (cyc == m_bus_cyc) ? m_bus_data : m_hold_data;
    e_rsp   = (cyc == m_rsp_cyc) ? NR'(1 << m_rsp_g) : '0;
    e_err   = (cyc == m_rsp_cyc) ? m_rsp_err : 1'b0;
    e_rdata = (cyc == m_rsp_cyc) ? m_rsp_rdata : '0;

    if (m_live) begin
      chk("req_ready", req_if.req_ready, e_ready);
      chk("cmd", bus_if.cmd, e_cmd);
      chk("cmd_addr", bus_if.cmd_addr, e_addr);
      chk("cmd_data_w", bus_if.cmd_data_w, e_data);
      chk("rsp_valid", req_if.rsp_valid, e_rsp);
      if (e_rsp != '0 || m_after_rst) begin
        chk("rsp_err", req_if.rsp_err, e_err);
        chk("rsp_rdata", req_if.rsp_rdata, e_rdata);
      end
    end

    if ((req_if.req_valid & req_if.req_ready) != '0) begin
      acc_cyc_log.push_back(cyc);
      acc_g_log.push_back(req_if.req_ready[1] ? 1 : 0);
    end
    if (req_if.rsp_valid != '0) begin
      rsp_cyc_log.push_back(cyc);
      rsp_g_log.push_back(req_if.rsp_valid[1] ? 1 : 0);
      rsp_err_log.push_back(req_if.rsp_err);
      rsp_data_log.push_back(req_if.rsp_rdata);
      $display("cycle %0d: rsp to req%0d err=%0d rdata=%08h", cyc, req_if.rsp_valid[1] ? 1 : 0,
               req_if.rsp_err, req_if.rsp_rdata);
    end
    if (bus_if.cmd !== CMD_IDLE) begin
      bus_cyc_log.push_back(cyc);
      bus_addr_log.push_back(bus_if.cmd_addr);
      bus_data_log.push_back(bus_if.cmd_data_w);
    end

    if (rst) begin
      m_live      = 1'b1;
      m_after_rst = 1'b1;
      m_free_at   = cyc + 1;
      m_last_g    = NR - 1;
      m_bus_cyc   = -1;
      m_rsp_cyc   = -1;
      m_hold_addr = '0;
      m_hold_data = '0;
    end else begin
      m_after_rst = 1'b0;
      if (cyc == m_bus_cyc) begin
        m_hold_addr = m_bus_addr;
        m_hold_data = m_bus_data;
      end
      if (e_ready != '0) begin
        g        = e_ready[1] ? 1 : 0;
        m_last_g = g;
        a_cmd    = req_if.req_cmd[2*g +: 2];
        a_addr   = req_if.req_addr[AW*g +: AW];
        a_data   = req_if.req_wdata[DW*g +: DW];
        m_rsp_g  = g;
        if (a_cmd == CMD_WR || a_cmd == CMD_RD) begin
          m_bus_cyc  = cyc + 1;
          m_bus_cmd  = a_cmd;
          m_bus_addr = a_addr;
          m_bus_data = a_data;
          m_rsp_err  = 1'b0;
          if (a_cmd == CMD_WR) begin
            m_mem[a_addr] = a_data;
            m_rsp_cyc     = cyc + 2;
            m_rsp_rdata   = '0;
            m_free_at     = cyc + 3;
          end else begin
            m_rsp_cyc   = cyc + 3;
            m_rsp_rdata = m_mem[a_addr];
            m_free_at   = cyc + 4;
          end
        end else begin
          m_rsp_cyc   = cyc + 1;
          m_rsp_err   = 1'b1;
          m_rsp_rdata = '0;
          m_free_at   = cyc + 2;
        end
      end
    end
    cyc++;
  end

  task automatic clear_logs();
    acc_cyc_log.delete(); acc_g_log.delete();
    rsp_cyc_log.delete(); rsp_g_log.delete(); rsp_err_log.delete(); rsp_data_log.delete();
    bus_cyc_log.delete(); bus_addr_log.delete(); bus_data_log.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req_if.req_valid != '0 || cyc < m_free_at) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_if.req_valid = '0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = '0;
      m_mem[i]   = '0;
    end
    bus_mem[8'h10] = 32'h0000_00A5; m_mem[8'h10] = 32'h0000_00A5;
    bus_mem[8'h20] = 32'h1234_5678; m_mem[8'h20] = 32'h1234_5678;
    req_if.req_valid = '0;
    req_if.req_cmd   = '0;
    req_if.req_addr  = '0;
    req_if.req_wdata = '0;
    bus_if.cmd_data_r = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd", bus_if.cmd, 2'b00);
    chk("reset_cmd_addr", bus_if.cmd_addr, 8'h00);
    chk("reset_rsp_valid", req_if.rsp_valid, 2'b00);
    chk("reset_rsp_rdata", req_if.rsp_rdata, 32'h0);

    // single write from req0
    clear_logs();
    push(0, CMD_WR, 8'h04, 32'hDEAD_BEEF);
    drain("wr0");
    chk("wr0_nbus", bus_cyc_log.size(), 1);
    chk("wr0_bus_lat", bus_cyc_log[0] - acc_cyc_log[0], 1);
    chk("wr0_bus_addr", bus_addr_log[0], 8'h04);
    chk("wr0_bus_data", bus_data_log[0], 32'hDEAD_BEEF);
    chk("wr0_nrsp", rsp_cyc_log.size(), 1);
    chk("wr0_rsp_lat", rsp_cyc_log[0] - acc_cyc_log[0], 2);
    chk("wr0_rsp_g", rsp_g_log[0], 0);
    chk("wr0_rsp_rdata", rsp_data_log[0], 32'h0);

    // read from req1
    clear_logs();
    push(1, CMD_RD, 8'h10, 32'h0);
    drain("rd1");
    chk("rd1_nrsp", rsp_cyc_log.size(), 1);
    chk("rd1_rsp_lat", rsp_cyc_log[0] - acc_cyc_log[0], 3);
    chk("rd1_rsp_g", rsp_g_log[0], 1);
    chk("rd1_rsp_rdata", rsp_data_log[0], 32'h0000_00A5);

    // both requesters continuously valid with writes
    do_reset();
    clear_logs();
    push(0, CMD_WR, 8'h30, 32'h0000_0030);
    push(0, CMD_WR, 8'h31, 32'h0000_0031);
    push(1, CMD_WR, 8'h40, 32'h0000_0040);
    push(1, CMD_WR, 8'h41, 32'h0000_0041);
    drain("alt");
    chk("alt_nacc", acc_g_log.size(), 4);
    chk("alt_g0", acc_g_log[0], 0);
    chk("alt_g1", acc_g_log[1], 1);
    chk("alt_g2", acc_g_log[2], 0);
    chk("alt_g3", acc_g_log[3], 1);
    chk("alt_gap", acc_cyc_log[1] - acc_cyc_log[0], 3);

    // illegal commands: no bus cycle, immediate error response
    clear_logs();
    push(0, 2'b11, 8'h55, 32'h1111_1111);
    drain("ill0");
    push(1, CMD_IDLE, 8'h66, 32'h2222_2222);
    drain("ill1");
    chk("ill_nbus", bus_cyc_log.size(), 0);
    chk("ill_nrsp", rsp_cyc_log.size(), 2);
    chk("ill0_rsp_lat", rsp_cyc_log[0] - acc_cyc_log[0], 1);
    chk("ill0_rsp_g", rsp_g_log[0], 0);
    chk("ill0_rsp_err", rsp_err_log[0], 1'b1);
    chk("ill0_rsp_rdata", rsp_data_log[0], 32'h0);
    chk("ill1_rsp_g", rsp_g_log[1], 1);
    chk("ill1_rsp_err", rsp_err_log[1], 1'b1);

    // reset during RDWAIT drops the read
    clear_logs();
    push(1, CMD_RD, 8'h20, 32'h0);
    begin
      int n;
      n = 0;
      while (!(req_if.req_valid[1] && req_if.req_ready[1]) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("rstmid_accept_seen", (n < 50), 1'b1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rsp_valid", req_if.rsp_valid, 2'b00);
    chk("rstmid_cmd", bus_if.cmd, 2'b00);
    chk("rstmid_cmd_addr", bus_if.cmd_addr, 8'h00);
    repeat (4) @(negedge clk);
    chk("rstmid_nrsp", rsp_cyc_log.size(), 0);
    clear_logs();
    push(0, CMD_WR, 8'h50, 32'h0000_0050);
    push(1, CMD_RD, 8'h20, 32'h0);
    drain("rstmid_tie");
    chk("tie_first_g", acc_g_log[0], 0);
    chk("tie_second_g", acc_g_log[1], 1);
    chk("tie_rd_rdata", rsp_data_log[1], 32'h1234_5678);

    // back-to-back reads from req0
    clear_logs();
    push(0, CMD_RD, 8'h10, 32'h0);
    push(0, CMD_RD, 8'h04, 32'h0);
    drain("b2b");
    chk("b2b_gap", acc_cyc_log[1] - acc_cyc_log[0], 4);
    chk("b2b_rdata0", rsp_data_log[0], 32'h0000_00A5);
    chk("b2b_rdata1", rsp_data_log[1], 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule
